// File: rtl/not_array_fault_checker.sv
// Self-test controller for a WIDTH-bit inverter array: applies all-zeros then all-ones,
// captures the array outputs after SETTLE cycles each and classifies every channel.
module not_array_fault_checker #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2,
    parameter int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    input  logic [WIDTH-1:0] dut_z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo_fail_mask,
    output logic [WIDTH-1:0] hi_fail_mask,
    output logic [WIDTH-1:0] dual_fail_mask,
    output logic [CNT_W-1:0] fault_count,
    output logic             pass
);

    localparam int              SC_W = $clog2(SETTLE) + 1;
    localparam logic [SC_W-1:0] LAST = SC_W'(SETTLE - 1);

    typedef enum logic [2:0] {IDLE, APPLY0, APPLY1, EVAL, DONE} state_e;

    state_e            state, state_next;
    logic [SC_W-1:0]   cnt;
    logic [WIDTH-1:0]  z0, z1;
    logic              settled;
    logic [WIDTH-1:0]  lo_vec, hi_vec;
    logic [CNT_W-1:0]  count_next;

    assign settled = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start)   state_next = APPLY0;
            APPLY0:  if (settled) state_next = APPLY1;
            APPLY1:  if (settled) state_next = EVAL;
            EVAL:                 state_next = DONE;
            DONE:                 state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        dut_a = '0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            APPLY0:  busy = 1'b1;
            APPLY1: begin
                busy  = 1'b1;
                dut_a = '1;
            end
            EVAL:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // A healthy inverter reads 1 under A=0 and 0 under A=1; anything else is a failure.
    always_comb begin
        lo_vec     = ~z0;
        hi_vec     = z1;
        count_next = '0;
        for (int i = 0; i < WIDTH; i++)
            count_next = count_next + CNT_W'(lo_vec[i] | hi_vec[i]);
    end

    // NOTE: every datapath register, captures and results alike, is cleared by
    // reset so an aborted run leaves no partial capture behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            z0             <= '0;
            z1             <= '0;
            lo_fail_mask   <= '0;
            hi_fail_mask   <= '0;
            dual_fail_mask <= '0;
            fault_count    <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                APPLY0: begin
                    if (settled) begin
                        z0  <= dut_z;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                APPLY1: begin
                    if (settled) begin
                        z1  <= dut_z;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EVAL: begin
                    lo_fail_mask   <= lo_vec & ~hi_vec;
                    hi_fail_mask   <= hi_vec & ~lo_vec;
                    dual_fail_mask <= lo_vec & hi_vec;
                    fault_count    <= count_next;
                    pass           <= (count_next == '0);
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
